// File: rtl/binary_game_round_controller.sv
// ---------------------------------------------------------------------------
// binary_game_round_controller
//
// Sequences one session of the DIP-switch binary counting game. A free-running
// 8-bit Galois LFSR supplies round targets, an external tick strobe times each
// round, and an answer is accepted only once the switches have matched the
// target for HOLD_CYCLES consecutive clocks. Score and lives are tracked here;
// the top level maps these outputs onto uo_out/uio_out.
//
// Optional feature macro: ROUND_TIME_RAMP_EN
//   defined   : round time = max(MIN_TICKS, ROUND_TICKS - score_o[7:2])
//   undefined : round time = ROUND_TICKS (MIN_TICKS only range-checked)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   start_i      in   single-cycle start pulse (synchronised)
//   tick_i       in   single-cycle round-timer strobe
//   switches_i   in   [7:0] DIP switch value (synchronised)
//   target_o     out  [7:0] number the player must set
//   score_o      out  [7:0] correct answers, saturating at 255
//   lives_o      out  [1:0] remaining lives
//   time_left_o  out  [3:0] ticks remaining in the current round
//   state_o      out  [2:0] FSM state code
//   hit_o        out  one-cycle pulse while in HIT
//   miss_o       out  one-cycle pulse while in MISS
//   game_over_o  out  high while in GAME_OVER
//
// State table
//   state        | meaning
//   IDLE      (0)| waiting for the first start pulse
//   NEW_ROUND (1)| picking a fresh target from the LFSR
//   PLAY      (2)| timing the round, counting the switch-match hold window
//   HIT       (3)| one cycle: correct answer, score increments
//   MISS      (4)| one cycle: round timed out, one life lost
//   GAME_OVER (5)| lives exhausted, waiting for start
// ---------------------------------------------------------------------------
module binary_game_round_controller #(
   parameter int unsigned ROUND_TICKS = 10,
   parameter int unsigned MIN_TICKS   = 3,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned LIVES       = 3,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       tick_i,
   input  logic [7:0] switches_i,
   output logic [7:0] target_o,
   output logic [7:0] score_o,
   output logic [1:0] lives_o,
   output logic [3:0] time_left_o,
   output logic [2:0] state_o,
   output logic       hit_o,
   output logic       miss_o,
   output logic       game_over_o
);

   localparam int unsigned      CNT_W      = $clog2(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
   localparam logic [3:0]       ROUND_T    = 4'(ROUND_TICKS);

   if (ROUND_TICKS < 1 || ROUND_TICKS > 15 || HOLD_CYCLES < 2 || LIVES < 1 || LIVES > 3 ||
       MIN_TICKS < 1 || MIN_TICKS > 15 || LFSR_SEED == 8'h00) begin : g_bad_params
      $error("binary_game_round_controller: parameter out of legal range");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_NEW_ROUND = 3'd1,
      ST_PLAY      = 3'd2,
      ST_HIT       = 3'd3,
      ST_MISS      = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   state_t           r_state;
   logic [7:0]       r_lfsr;
   logic [7:0]       r_target;
   logic [7:0]       r_score;
   logic [1:0]       r_lives;
   logic [3:0]       r_time;
   logic [CNT_W-1:0] r_match_cnt;
   logic             r_hit;
   logic             r_miss;
   logic             r_game_over;

   logic [7:0]       w_lfsr_next;
   logic             w_match;
   logic             w_hold_done;
   logic [3:0]       w_round_time;

   // Galois form, shift right, taps 8'hB8: maximal length, so zero is never reached
   assign w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);

   assign w_match     = (switches_i == r_target);
   // counter already holds HOLD_CYCLES-1 prior matches, so this cycle is the last one
   assign w_hold_done = w_match && (r_match_cnt == HOLD_LAST);

`ifdef ROUND_TIME_RAMP_EN
   localparam logic [7:0] MIN_T8   = 8'(MIN_TICKS);
   localparam logic [7:0] ROUND_T8 = 8'(ROUND_TICKS);
   logic [7:0] w_ramp_step;
   assign w_ramp_step  = {2'b00, r_score[7:2]};
   // compare in 8 bits so a large score cannot wrap the subtraction
   assign w_round_time = ((w_ramp_step + MIN_T8) >= ROUND_T8) ? MIN_T8[3:0]
                                                              : 4'(ROUND_T8 - w_ramp_step);
`else
   assign w_round_time = ROUND_T;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_lfsr      <= LFSR_SEED;
         r_target    <= 8'h00;
         r_score     <= 8'h00;
         r_lives     <= LIVES_INIT;
         r_time      <= 4'd0;
         r_match_cnt <= '0;
         r_hit       <= 1'b0;
         r_miss      <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_lfsr <= w_lfsr_next;
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_score <= 8'h00;
                  r_lives <= LIVES_INIT;
                  r_state <= ST_NEW_ROUND;
               end
            end
            ST_NEW_ROUND: begin
               // reject a repeat target or one the switches already show
               if (r_lfsr != r_target && r_lfsr != switches_i) begin
                  r_target    <= r_lfsr;
                  r_time      <= w_round_time;
                  r_match_cnt <= '0;
                  r_state     <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (w_hold_done) begin
                  // a completed hold beats a simultaneous final tick
                  r_hit       <= 1'b1;
                  r_match_cnt <= '0;
                  r_state     <= ST_HIT;
               end else begin
                  r_match_cnt <= w_match ? r_match_cnt + 1'b1 : '0;
                  if (tick_i && r_time != 4'd0) begin
                     r_time <= r_time - 4'd1;
                     if (r_time == 4'd1) begin
                        r_miss  <= 1'b1;
                        r_state <= ST_MISS;
                     end
                  end
               end
            end
            ST_HIT: begin
               if (r_score != 8'hFF) begin
                  r_score <= r_score + 8'd1;
               end
               r_state <= ST_NEW_ROUND;
            end
            ST_MISS: begin
               r_lives <= r_lives - 2'd1;
               if (r_lives == 2'd1) begin
                  r_game_over <= 1'b1;
                  r_state     <= ST_GAME_OVER;
               end else begin
                  r_state <= ST_NEW_ROUND;
               end
            end
            ST_GAME_OVER: begin
               if (start_i) begin
                  r_score     <= 8'h00;
                  r_lives     <= LIVES_INIT;
                  r_game_over <= 1'b0;
                  r_state     <= ST_NEW_ROUND;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign target_o    = r_target;
   assign score_o     = r_score;
   assign lives_o     = r_lives;
   assign time_left_o = r_time;
   assign state_o     = r_state;
   assign hit_o       = r_hit;
   assign miss_o      = r_miss;
   assign game_over_o = r_game_over;

endmodule
